// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multicycle controller.
// Holds the controller state enum, the base opcodes the controller
// recognises, the datapath select encodings, the trap-cause codes and
// the combinational immediate-format decode.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRPC,
        S_LUI,
        S_TRAP
    } state_t;

    // Opcodes (instruction bits 6:0)
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // ALU A operand
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU B operand
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Trap causes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Immediate format straight from the opcode; unknown opcodes map to
    // the I format so the output is never X.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            OP_LUI:    imm = IMM_U;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

    // States that wait on the memory handshake
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath.
//   op, mem_ready            : datapath/memory -> controller
//   PCUpdate .. TrapCause    : controller -> datapath
// master = controller side, slave = datapath side.
interface main_fsm_if;
    logic [6:0] op;
    logic       mem_ready;
    logic       PCUpdate;
    logic       Branch;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       Jalr;
    logic       Trap;
    logic [1:0] TrapCause;

    modport master (
        input  op, mem_ready,
        output PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Jalr, Trap, TrapCause
    );

    modport slave (
        output op, mem_ready,
        input  PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Jalr, Trap, TrapCause
    );
endinterface

// File: rtl/main_fsm_mem_wait_timer.sv
// Memory wait timer for the main controller.
// Counts consecutive stalled cycles in a memory-wait state and flags when
// the count has reached MEM_TIMEOUT. MEM_TIMEOUT = 0 disables it.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : a memory-wait state is being entered; restart from 0
//   waiting    : currently in a memory-wait state with mem_ready low
//   expired    : counter sits at MEM_TIMEOUT
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is updated with <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (waiting && (cnt != LIMIT)) begin
            // Saturates at the limit rather than wrapping
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/main_fsm.sv
// Multicycle main controller for the RV32I core.
// Steps each instruction through FETCH / DECODE / execute / writeback
// states and drives the datapath enables and selects for each state.
// Memory states stall on mem_ready; a stall lasting past MEM_TIMEOUT
// cycles halts the controller in TRAP (cause 10) until reset.
// Optional build macro MAIN_FSM_ILLEGAL_TRAP_EN: when defined, an unknown
// opcode in DECODE traps with cause 01; otherwise it runs as a nop.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : main_fsm_if.master - op/mem_ready in, datapath controls out
module main_fsm
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    main_fsm_if.master    bus
);

    state_t     state, next_state;
    logic [1:0] trap_cause, next_cause;

    logic timer_clear, timer_waiting, timer_expired, timeout;

    logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write;
    logic       jalr, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    // ------------------------------------------------------------------
    // Wait timer: restarts on entry to any memory-wait state, counts while
    // that state is stalled.
    // ------------------------------------------------------------------
    assign timer_clear   = is_mem_wait(next_state) && (next_state != state);
    assign timer_waiting = is_mem_wait(state) && !bus.mem_ready;
    assign timeout       = timer_waiting && timer_expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .waiting (timer_waiting),
        .expired (timer_expired)
    );

    // ------------------------------------------------------------------
    // State and trap-cause registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            trap_cause <= TRAP_NONE;
        end else begin
            state      <= next_state;
            trap_cause <= next_cause;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        next_cause = trap_cause;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    default: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                        next_state = S_TRAP;
                        next_cause = TRAP_ILLEGAL;
`else
                        next_state = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR:  next_state = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (bus.mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_TIMEOUT;
                end
            end
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = TRAP_TIMEOUT;
                end
            end
            S_EXECR:   next_state = S_ALUWB;
            S_EXECI:   next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JAL:     next_state = S_ALUWB;   // ALUWB writes OldPC+4
            S_JALR:    next_state = S_JALRPC;
            S_JALRPC:  next_state = S_ALUWB;
            S_LUI:     next_state = S_FETCH;
            S_TRAP:    next_state = S_TRAP;    // only reset leaves
            default:   next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore except FETCH's IRWrite/PCUpdate on mem_ready)
    // ------------------------------------------------------------------
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        jalr       = 1'b0;
        trap       = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.mem_ready;
                pc_update  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_BRANCH;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_JALRPC: begin
                // PC <= ALUOut (RD1+imm, bit 0 cleared); ALU forms OldPC+4
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                jalr      = 1'b1;
            end
            S_LUI: begin
                result_src = RES_IMMEXT;
                reg_write  = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCUpdate  = pc_update;
    assign bus.Branch    = branch;
    assign bus.AdrSrc    = adr_src;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.RegWrite  = reg_write;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ImmSrc    = imm_src_of(bus.op);
    assign bus.Jalr      = jalr;
    assign bus.Trap      = trap;
    assign bus.TrapCause = trap_cause;

endmodule
